// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A one-bit counter is the floor, even for degenerate widths.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, bo = borrow out.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first; done pulses WIDTH cycles after the accepted start.
// No backpressure: start is only sampled in IDLE and is dropped while busy.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stage_d, stage_bo;

  full_subtractor u_stage (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .bi (br_q),
    .d  (stage_d),
    .bo (stage_bo)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sd_d  = {stage_d, sd_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = stage_bo;
        cnt_d = cnt_q + CW'(1);
        // Outputs update only on the last bit so partial results never leak.
        if (cnt_q == CNT_LAST) begin
          diff_d  = {stage_d, sd_q[WIDTH-1:1]};
          bout_d  = stage_bo;
          cnt_d   = cnt_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
